// File: rtl/cbus_mem_model.sv
// cbus simulation memory + CLINT responder: round-robin multi-port slave with
// LFSR-driven latency, a 64-bit word array and sticky protocol-error reporting.

package cbus_pkg;
  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [63:0] data;
    logic [7:0]  strobe;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

// Per-port response driver: only the selected port ever sees a non-zero response.
module cbus_mem_model_port
  import cbus_pkg::*;
(
  input  logic        sel,
  input  logic        last,
  input  logic [63:0] rdata,
  output cbus_resp_t  resp
);
  // zero unless this port owns the beat in flight
  always_comb begin
    resp = '0;
    if (sel) begin
      resp.ready = 1'b1;
      resp.last  = last;
      resp.data  = rdata;
    end
  end
endmodule

module cbus_mem_model
  import cbus_pkg::*;
#(
  parameter int          NPORTS     = 2,
  parameter int          DEPTH      = 65536,
  parameter logic [63:0] MEM_BASE   = 64'h8000_0000,
  parameter int          LAT_MIN    = 2,
  parameter int          LAT_MAX    = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [63:0] CLINT_BASE = 64'h3800_0000,
  parameter int          TICK_DIV   = 26,
  localparam int         EW         = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  cbus_req_t [NPORTS-1:0]  oreq,
  output cbus_resp_t [NPORTS-1:0] oresp,
  output logic                    trint,
  output logic                    swint,
  output logic                    protocol_err,
  output logic [EW-1:0]           err_port
);
  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          DW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH) << 3;
  localparam logic [31:0] LAT_RANGE = 32'(LAT_MAX - LAT_MIN + 1);
  localparam logic [63:0] A_MSIP    = CLINT_BASE;
  localparam logic [63:0] A_CMP     = CLINT_BASE + 64'h4000;
  localparam logic [63:0] A_MTIME   = CLINT_BASE + 64'hBFF8;

  typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

  state_t          state, state_nx;
  logic [EW-1:0]   ptr, grant, arb_idx;
  logic            arb_hit;
  cbus_req_t       arb_req, arb_req_m, cur, cur_m, saved;
  logic [15:0]     lfsr, cnt, lat;
  logic [63:0]     addr, addr_nx, off, rdata, wmask;
  logic [7:0]      beats;
  logic            hit_msip, hit_cmp, hit_mtime, in_mem, oob, we;
  logic            misalign, mismatch, viol;
  logic [EW-1:0]   viol_port;
  logic [IW-1:0]   widx;
  logic [63:0]     mtime, mtimecmp;
  logic            msip;
  logic [DW-1:0]   div_cnt;
  logic [63:0]     mem [DEPTH];

  // round-robin: lowest valid port at or after ptr; scanning downward lets the
  // nearest one win
  always_comb begin
    logic [EW-1:0] pi;
    arb_hit = 1'b0;
    arb_idx = '0;
    pi      = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      pi = EW'((int'(ptr) + i) % NPORTS);
      if (oreq[pi].valid) begin
        arb_hit = 1'b1;
        arb_idx = pi;
      end
    end
  end

  // request views with data/strobe masked: those legitimately change per beat
  always_comb begin
    arb_req          = oreq[arb_idx];
    arb_req_m        = arb_req;
    arb_req_m.data   = '0;
    arb_req_m.strobe = '0;
    cur              = oreq[grant];
    cur_m            = cur;
    cur_m.data       = '0;
    cur_m.strobe     = '0;
    lat              = 16'(LAT_MIN) + 16'(32'(lfsr) % LAT_RANGE);
    for (int b = 0; b < 8; b++) wmask[8*b +: 8] = {8{cur.strobe[b]}};
  end

  // next beat address for FIXED / INCR / WRAP
  always_comb begin
    logic [63:0] sz, win, lo, inc;
    sz      = 64'd1 << saved.size;
    win     = (64'(saved.len) + 64'd1) << saved.size;
    lo      = saved.addr & ~(win - 64'd1);
    inc     = addr + sz;
    addr_nx = inc;
    if (saved.burst == BURST_FIXED)     addr_nx = addr;
    else if (saved.burst == BURST_WRAP) addr_nx = (inc == lo + win) ? lo : inc;
  end

  // address decode and read mux; unmapped addresses read 0
  always_comb begin
    off       = addr - MEM_BASE;
    widx      = off[IW+2:3];
    hit_msip  = addr[63:3] == A_MSIP[63:3];
    hit_cmp   = addr[63:3] == A_CMP[63:3];
    hit_mtime = addr[63:3] == A_MTIME[63:3];
    in_mem    = (addr >= MEM_BASE) && (off < MEM_BYTES);
    oob       = !(hit_msip || hit_cmp || hit_mtime || in_mem);
    we        = (state == XFER) && saved.is_write;
    rdata     = '0;
    if (hit_msip)       rdata = {63'd0, msip};
    else if (hit_cmp)   rdata = mtimecmp;
    else if (hit_mtime) rdata = mtime;
    else if (in_mem)    rdata = mem[widx];
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  // FSM next state; cnt holds the number of WAIT cycles still to spend
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (arb_hit) state_nx = (lat == 16'd0) ? XFER : WAIT;
      WAIT:    if (cnt <= 16'd1) state_nx = XFER;
      XFER:    if (beats == 8'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // grant capture, latency counter, beat tracking, free-running LFSR
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr   <= '0;
      grant <= '0;
      saved <= '0;
      cnt   <= '0;
      addr  <= '0;
      beats <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      case (state)
        IDLE: if (arb_hit) begin
          grant <= arb_idx;
          ptr   <= EW'((int'(arb_idx) + 1) % NPORTS);
          saved <= arb_req_m;
          cnt   <= lat;
          addr  <= arb_req.addr;
          beats <= arb_req.len;
        end
        WAIT: begin
          cnt <= cnt - 16'd1;
          if (cnt <= 16'd1) begin
            addr  <= saved.addr;
            beats <= saved.len;
          end
        end
        XFER: begin
          if (beats != 8'd0) beats <= beats - 8'd1;
          addr <= addr_nx;
        end
        default: ;
      endcase
    end
  end

  // array writes; the array itself is never reset
  always_ff @(posedge clk) begin
    if (we && in_mem && !(hit_msip || hit_cmp || hit_mtime))
      mem[widx] <= (mem[widx] & ~wmask) | (cur.data & wmask);
  end

  // CLINT registers and timer; a bus write to mtime beats the tick
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mtime    <= '0;
      mtimecmp <= '1;
      msip     <= 1'b0;
      div_cnt  <= '0;
      trint    <= 1'b0;
      swint    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DW'(TICK_DIV - 1)) ? '0 : div_cnt + DW'(1);
      if (we && hit_mtime)                     mtime <= (mtime & ~wmask) | (cur.data & wmask);
      else if (div_cnt == DW'(TICK_DIV - 1))   mtime <= mtime + 64'd1;
      if (we && hit_cmp)                       mtimecmp <= (mtimecmp & ~wmask) | (cur.data & wmask);
      if (we && hit_msip && cur.strobe[0])     msip <= cur.data[0];
      trint <= (mtime >= mtimecmp);
      swint <= msip;
    end
  end

  // violation detect: misalignment at grant, request drift while owned, unmapped beat
  always_comb begin
    misalign  = (arb_req.addr & ((64'd1 << arb_req.size) - 64'd1)) != 64'd0;
    mismatch  = cur_m != saved;
    viol      = ((state == IDLE) && arb_hit && misalign) ||
                ((state == WAIT) && mismatch) ||
                ((state == XFER) && (mismatch || oob));
    viol_port = (state == IDLE) ? arb_idx : grant;
  end

  // sticky error flag; err_port remembers only the first offender
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      protocol_err <= 1'b0;
      err_port     <= '0;
    end else if (viol && !protocol_err) begin
      protocol_err <= 1'b1;
      err_port     <= viol_port;
    end
  end

  for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
    cbus_mem_model_port u_port (
      .sel   ((state == XFER) && (grant == EW'(gi))),
      .last  (beats == 8'd0),
      .rdata (rdata),
      .resp  (oresp[gi])
    );
  end
endmodule

// File: tb/tb_cbus_mem_model.sv
// Directed bench for cbus_mem_model: stimulus pushes expected beats into a
// scoreboard queue, a negedge monitor pops and compares every ready beat.
module tb_cbus_mem_model;
  import cbus_pkg::*;

  localparam logic [63:0] MB = 64'h8000_0000;
  localparam logic [63:0] CB = 64'h3800_0000;

  logic              clk = 1'b0;
  logic              resetn;
  cbus_req_t  [1:0]  oreq;
  cbus_resp_t [1:0]  oresp;
  logic              trint, swint, protocol_err;
  logic [0:0]        err_port;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          port;
    bit          last;
    bit          chk;
    logic [63:0] data;
  } exp_t;
  exp_t sb[$];

  logic [63:0] wd [4];
  logic [63:0] ed [4];

  cbus_mem_model #(
    .NPORTS(2), .DEPTH(1024), .MEM_BASE(MB), .LAT_MIN(3), .LAT_MAX(3),
    .LFSR_SEED(16'hACE1), .CLINT_BASE(CB), .TICK_DIV(4)
  ) dut (
    .clk(clk), .resetn(resetn), .oreq(oreq), .oresp(oresp), .trint(trint),
    .swint(swint), .protocol_err(protocol_err), .err_port(err_port)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: every ready beat must match the head of the scoreboard
  always @(negedge clk) begin : mon
    exp_t       e;
    cbus_resp_t other;
    if (resetn === 1'b1) begin
      for (int p = 0; p < 2; p++) begin
        if (oresp[p].ready === 1'b1) begin
          other = (p == 0) ? oresp[1] : oresp[0];
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected beat: port %0d data %h", p, oresp[p].data);
          end else begin
            e = sb.pop_front();
            chk("beat port", 64'(p), 64'(e.port));
            chk("beat last", 64'(oresp[p].last), 64'(e.last));
            if (e.chk) chk("beat data", oresp[p].data, e.data);
            chk("idle port quiet", 64'(other.ready) | 64'(other.last) | other.data, 64'd0);
          end
        end
      end
    end
  end

  // one burst on port p; wd[] supplies write beats, ed[] expected read beats
  task automatic xfer(input int p, input bit wr, input logic [63:0] a, input int len,
                      input logic [1:0] bt, input logic [7:0] strb, output int lat);
    cbus_req_t r;
    int beat, cyc;
    bit hit;
    for (int i = 0; i <= len; i++) sb.push_back('{p, (i == len), !wr, ed[i]});
    r = '0;
    r.valid = 1'b1; r.is_write = wr; r.size = 3'd3; r.addr = a;
    r.len = 8'(len); r.burst = bt; r.data = wd[0]; r.strobe = strb;
    oreq[p] = r;
    beat = 0; cyc = 0; lat = -1;
    while (beat <= len && cyc < 100) begin
      @(negedge clk);
      hit = (oresp[p].ready === 1'b1);
      if (hit && lat < 0) lat = cyc;
      @(posedge clk); #1;
      cyc++;
      if (hit) begin
        beat++;
        if (beat <= len) begin
          r.data = wd[beat];
          oreq[p] = r;
        end
      end
    end
    oreq[p] = '0;
    if (beat <= len) begin
      total++; bad++;
      $display("FAIL xfer timeout: port %0d addr %h beats %0d want %0d", p, a, beat, len + 1);
    end
  endtask

  initial begin : stim
    cbus_req_t r0, r1;
    int  lat;
    bit  found;

    resetn = 1'b0;
    oreq   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset oresp0", 64'(oresp[0].ready) | 64'(oresp[0].last) | oresp[0].data, 64'd0);
    chk("reset oresp1", 64'(oresp[1].ready) | 64'(oresp[1].last) | oresp[1].data, 64'd0);
    chk("reset trint", 64'(trint), 64'd0);
    chk("reset swint", 64'(swint), 64'd0);
    chk("reset protocol_err", 64'(protocol_err), 64'd0);
    chk("reset err_port", 64'(err_port), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // INCR write then readback
    wd = '{64'h11, 64'h22, 64'h33, 64'h44};
    xfer(0, 1'b1, MB, 3, BURST_INCR, 8'hFF, lat);
    ed = '{64'h11, 64'h22, 64'h33, 64'h44};
    xfer(0, 1'b0, MB, 3, BURST_INCR, 8'hFF, lat);

    // single read: 1 IDLE + 3 WAIT, beat appears after 4 edges
    ed[0] = 64'h33;
    xfer(0, 1'b0, MB + 64'h10, 0, BURST_INCR, 8'hFF, lat);
    chk("single read latency", 64'(lat), 64'd4);

    // WRAP from offset 0x18: 0x18,0x00,0x08,0x10
    ed = '{64'h44, 64'h11, 64'h22, 64'h33};
    xfer(0, 1'b0, MB + 64'h18, 3, BURST_WRAP, 8'hFF, lat);

    // partial strobe on word 1, then FIXED two-beat read of it
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    xfer(0, 1'b1, MB + 64'h8, 0, BURST_INCR, 8'h0F, lat);
    ed[0] = 64'h0000_0000_AAAA_AAAA;
    ed[1] = 64'h0000_0000_AAAA_AAAA;
    xfer(0, 1'b0, MB + 64'h8, 1, BURST_FIXED, 8'hFF, lat);

    // both ports valid for four bursts; last grant was port0 so port1 leads
    r0 = '0; r0.valid = 1'b1; r0.size = 3'd3; r0.addr = MB;          r0.burst = BURST_INCR;
    r1 = '0; r1.valid = 1'b1; r1.size = 3'd3; r1.addr = MB + 64'h18; r1.burst = BURST_INCR;
    sb.push_back('{1, 1'b1, 1'b1, 64'h44});
    sb.push_back('{0, 1'b1, 1'b1, 64'h11});
    sb.push_back('{1, 1'b1, 1'b1, 64'h44});
    sb.push_back('{0, 1'b1, 1'b1, 64'h11});
    oreq[0] = r0;
    oreq[1] = r1;
    repeat (20) @(posedge clk);
    #1;
    oreq = '0;
    chk("alternation drained", 64'(sb.size()), 64'd0);

    // timer: mtimecmp=5, mtime=0, tick every 4 cycles
    wd[0] = 64'd5;
    xfer(0, 1'b1, CB + 64'h4000, 0, BURST_INCR, 8'hFF, lat);
    ed[0] = 64'd5;
    xfer(0, 1'b0, CB + 64'h4000, 0, BURST_INCR, 8'hFF, lat);
    wd[0] = 64'd0;
    xfer(0, 1'b1, CB + 64'hBFF8, 0, BURST_INCR, 8'hFF, lat);
    repeat (17) @(posedge clk);
    #1;
    chk("trint before mtime=5", 64'(trint), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("trint after mtime=5", 64'(trint), 64'd1);

    // software interrupt
    chk("swint idle", 64'(swint), 64'd0);
    wd[0] = 64'd1;
    xfer(0, 1'b1, CB, 0, BURST_INCR, 8'h01, lat);
    chk("swint same cycle", 64'(swint), 64'd0);
    @(posedge clk); #1;
    chk("swint next cycle", 64'(swint), 64'd1);
    ed[0] = 64'd1;
    xfer(0, 1'b0, CB, 0, BURST_INCR, 8'hFF, lat);

    // port1 changes addr during WAIT
    chk("no error yet", 64'(protocol_err), 64'd0);
    r1 = '0; r1.valid = 1'b1; r1.size = 3'd3; r1.addr = MB; r1.burst = BURST_INCR;
    sb.push_back('{1, 1'b1, 1'b1, 64'h11});
    oreq[1] = r1;
    repeat (2) @(posedge clk);
    #1;
    r1.addr = MB + 64'h8;
    oreq[1] = r1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = (oresp[1].ready === 1'b1);
      @(posedge clk); #1;
    end
    oreq = '0;
    if (!found) begin
      total++; bad++;
      $display("FAIL drift burst: no beat within 20 cycles");
    end
    chk("drift protocol_err", 64'(protocol_err), 64'd1);
    chk("drift err_port", 64'(err_port), 64'd1);

    // misaligned read on port0: served, but err_port keeps the first offender
    ed[0] = 64'h11;
    xfer(0, 1'b0, MB + 64'h4, 0, BURST_INCR, 8'hFF, lat);
    chk("sticky protocol_err", 64'(protocol_err), 64'd1);
    chk("first err_port kept", 64'(err_port), 64'd1);

    // reset in the middle of a write burst
    wd = '{64'h80, 64'h81, 64'h82, 64'h83};
    xfer(0, 1'b1, MB + 64'h40, 3, BURST_INCR, 8'hFF, lat);
    r0 = '0; r0.valid = 1'b1; r0.is_write = 1'b1; r0.size = 3'd3; r0.addr = MB + 64'h40;
    r0.len = 8'd3; r0.burst = BURST_INCR; r0.data = 64'hDEAD_BEEF; r0.strobe = 8'hFF;
    oreq[0] = r0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge clk); #1;
      found = (oresp[0].ready === 1'b1);
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL reset test: burst never reached XFER");
    end
    resetn = 1'b0;
    #1;
    chk("reset mid-burst oresp0", 64'(oresp[0].ready) | 64'(oresp[0].last) | oresp[0].data, 64'd0);
    chk("reset clears protocol_err", 64'(protocol_err), 64'd0);
    chk("reset clears err_port", 64'(err_port), 64'd0);
    oreq = '0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("trint after reset", 64'(trint), 64'd0);
    ed = '{64'h80, 64'h81, 64'h82, 64'h83};
    xfer(0, 1'b0, MB + 64'h40, 3, BURST_INCR, 8'hFF, lat);
    chk("clean after reset", 64'(protocol_err), 64'd0);

    // out-of-range read on port1 returns 0 and flags port1
    ed[0] = 64'd0;
    xfer(1, 1'b0, MB + 64'h2000, 0, BURST_INCR, 8'hFF, lat);
    chk("oob protocol_err", 64'(protocol_err), 64'd1);
    chk("oob err_port", 64'(err_port), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
